// File: rtl/mpu_rx_frame_filter_pkg.sv
// Shared types and constants for the MPU receive frame filter.
// Holds the parser state encoding and the payload buffer entry layout.
package mpu_eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DROP = 2'd3
    } rx_filt_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        eop;
        logic [1:0]  mod;
    } rx_buf_entry_t;

    localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
    localparam int          HDR_WORDS  = 4;

endpackage

// File: rtl/mpu_rx_frame_filter_sdp_ram.sv
// Simple dual-port RAM with registered read; read data holds while i_re is low,
// which the filter relies on to park a word when its output stage is stalled.
module mpu_sdp_ram #(
    parameter int WIDTH = 35,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mpu_rx_frame_filter.sv
// Store-and-forward receive filter: checks dst MAC / EtherType / error per frame,
// strips the shift16 header and forwards only good payloads as an Avalon-ST packet.
module mpu_rx_frame_filter
    import mpu_eth_pkg::*;
#(
    parameter int          DEPTH_LOG2   = 9,
    parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE    = 16'h88B5,
    parameter logic        ACCEPT_BCAST = 1'b1,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      ff_rx_data,
    input  logic             ff_rx_sop,
    input  logic             ff_rx_eop,
    input  logic [1:0]       ff_rx_mod,
    input  logic             ff_rx_err,
    input  logic             ff_rx_dval,
    output logic             ff_rx_rdy,
    output logic [31:0]      pay_data,
    output logic             pay_valid,
    input  logic             pay_ready,
    output logic             pay_sop,
    output logic             pay_eop,
    output logic [1:0]       pay_empty,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_filt,
    output logic [CNT_W-1:0] cnt_err,
    output logic [CNT_W-1:0] cnt_ovf
);

    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]            HIDX_LAST = 2'(HDR_WORDS - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    rx_filt_state_t          r_state, w_state_nxt;
    logic [1:0]              r_hidx, w_hidx_nxt;
    logic [47:0]             r_dst, w_dst_nxt;
    logic [DEPTH_LOG2-1:0]   r_wr, w_wr_nxt, r_commit, w_commit_nxt, r_rd, w_wr_inc;
    logic                    w_acc, w_full, w_we, w_dst_ok;
    logic                    w_inc_ok, w_inc_filt, w_inc_err, w_inc_ovf;
    logic [CNT_W-1:0]        r_cnt_ok, r_cnt_filt, r_cnt_err, r_cnt_ovf;
    rx_buf_entry_t           w_entry, w_rdata;
    logic                    r_rdy, r_ram_vld, r_first;
    logic                    w_out_free, w_s1_move, w_rd_en;
    logic                    r_pay_valid, r_pay_sop, r_pay_eop;
    logic [31:0]             r_pay_data;
    logic [1:0]              r_pay_empty;

    assign w_acc    = ff_rx_dval && r_rdy;
    assign w_wr_inc = r_wr + PTR_ONE;
    assign w_full   = (w_wr_inc == r_rd);
    assign w_dst_ok = (r_dst == MAC_ADDR) || (ACCEPT_BCAST && (r_dst == BCAST_ADDR));
    assign w_entry  = {ff_rx_data, ff_rx_eop, ff_rx_mod};

    // Parser next-state: header capture/evaluation, payload write, commit or rollback
    always_comb begin
        w_state_nxt  = r_state;
        w_hidx_nxt   = r_hidx;
        w_dst_nxt    = r_dst;
        w_wr_nxt     = r_wr;
        w_commit_nxt = r_commit;
        w_we         = 1'b0;
        w_inc_ok     = 1'b0;
        w_inc_filt   = 1'b0;
        w_inc_err    = 1'b0;
        w_inc_ovf    = 1'b0;
        if (!w_acc) begin
            w_state_nxt = r_state;
        end else if (ff_rx_sop) begin
            // A sop always opens a new header; a frame cut short mid-header/payload is an error
            w_wr_nxt          = r_commit;
            w_inc_err         = (r_state == ST_HDR) || (r_state == ST_PAY);
            w_hidx_nxt        = 2'd0;
            w_dst_nxt[47:32]  = ff_rx_data[15:0];
            w_inc_filt        = ff_rx_eop;
            w_state_nxt       = ff_rx_eop ? ST_IDLE : ST_HDR;
        end else begin
            case (r_state)
                ST_HDR: begin
                    w_hidx_nxt = r_hidx + 2'd1;
                    if (ff_rx_eop) begin
                        w_inc_filt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_hidx_nxt == HIDX_LAST) begin
                        if (w_dst_ok && (ff_rx_data[15:0] == ETHERTYPE)) begin
                            w_state_nxt = ST_PAY;
                        end else begin
                            w_inc_filt  = 1'b1;
                            w_state_nxt = ST_DROP;
                        end
                    end else if (w_hidx_nxt == 2'd1) begin
                        w_dst_nxt[31:0] = ff_rx_data;
                    end else begin
                        w_dst_nxt = r_dst;
                    end
                end
                ST_PAY: begin
                    if (w_full) begin
                        w_wr_nxt    = r_commit;
                        w_inc_ovf   = 1'b1;
                        w_state_nxt = ff_rx_eop ? ST_IDLE : ST_DROP;
                    end else if (ff_rx_eop && ff_rx_err) begin
                        w_wr_nxt    = r_commit;
                        w_inc_err   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_we     = 1'b1;
                        w_wr_nxt = w_wr_inc;
                        if (ff_rx_eop) begin
                            w_commit_nxt = w_wr_inc;
                            w_inc_ok     = 1'b1;
                            w_state_nxt  = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_PAY;
                        end
                    end
                end
                ST_DROP: begin
                    w_state_nxt = ff_rx_eop ? ST_IDLE : ST_DROP;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Parser state, header capture and write-side pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_hidx   <= 2'd0;
            r_dst    <= 48'd0;
            r_wr     <= PTR_ZERO;
            r_commit <= PTR_ZERO;
        end else begin
            r_state  <= w_state_nxt;
            r_hidx   <= w_hidx_nxt;
            r_dst    <= w_dst_nxt;
            r_wr     <= w_wr_nxt;
            r_commit <= w_commit_nxt;
        end
    end

    // Saturating frame statistics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_ok   <= CNT_ZERO;
            r_cnt_filt <= CNT_ZERO;
            r_cnt_err  <= CNT_ZERO;
            r_cnt_ovf  <= CNT_ZERO;
        end else begin
            r_cnt_ok   <= w_inc_ok   ? sat_inc(r_cnt_ok)   : r_cnt_ok;
            r_cnt_filt <= w_inc_filt ? sat_inc(r_cnt_filt) : r_cnt_filt;
            r_cnt_err  <= w_inc_err  ? sat_inc(r_cnt_err)  : r_cnt_err;
            r_cnt_ovf  <= w_inc_ovf  ? sat_inc(r_cnt_ovf)  : r_cnt_ovf;
        end
    end

    mpu_sdp_ram #(
        .WIDTH ($bits(rx_buf_entry_t)),
        .AW    (DEPTH_LOG2)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr),
        .i_wdata (w_entry),
        .i_re    (w_rd_en),
        .i_raddr (r_rd),
        .o_rdata (w_rdata)
    );

    // RAM output acts as a parked stage: no new read is issued until it can move on
    assign w_out_free = !r_pay_valid || pay_ready;
    assign w_s1_move  = r_ram_vld && w_out_free;
    assign w_rd_en    = (r_rd != r_commit) && (!r_ram_vld || w_s1_move);

    // Read pointer, RAM-stage valid and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdy       <= 1'b0;
            r_rd        <= PTR_ZERO;
            r_ram_vld   <= 1'b0;
            r_first     <= 1'b1;
            r_pay_valid <= 1'b0;
            r_pay_data  <= 32'd0;
            r_pay_sop   <= 1'b0;
            r_pay_eop   <= 1'b0;
            r_pay_empty <= 2'd0;
        end else begin
            r_rdy     <= 1'b1;
            r_rd      <= w_rd_en ? (r_rd + PTR_ONE) : r_rd;
            r_ram_vld <= w_rd_en || (r_ram_vld && !w_s1_move);
            if (w_s1_move) begin
                r_pay_valid <= 1'b1;
                r_pay_data  <= w_rdata.data;
                r_pay_sop   <= r_first;
                r_pay_eop   <= w_rdata.eop;
                r_pay_empty <= w_rdata.eop ? w_rdata.mod : 2'd0;
                r_first     <= w_rdata.eop;
            end else if (pay_ready) begin
                r_pay_valid <= 1'b0;
            end
        end
    end

    assign ff_rx_rdy = r_rdy;
    assign pay_valid = r_pay_valid;
    assign pay_data  = r_pay_data;
    assign pay_sop   = r_pay_sop;
    assign pay_eop   = r_pay_eop;
    assign pay_empty = r_pay_empty;
    assign cnt_ok    = r_cnt_ok;
    assign cnt_filt  = r_cnt_filt;
    assign cnt_err   = r_cnt_err;
    assign cnt_ovf   = r_cnt_ovf;

endmodule

// File: tb/tb_mpu_rx_frame_filter.sv
// Self-checking bench for mpu_rx_frame_filter: a frame-level reference model
// classifies each frame and queues the payload words the MPU side must see.
module tb_mpu_rx_frame_filter;

    localparam int          DL2   = 4;
    localparam int          CAP   = (1 << DL2) - 1;
    localparam logic [47:0] MAC   = 48'h0200_0000_0001;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER = 48'h0200_0000_0002;
    localparam logic [15:0] ET_OK = 16'h88B5;
    localparam logic [15:0] ET_IP = 16'h0800;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ff_rx_data;
    logic        ff_rx_sop, ff_rx_eop, ff_rx_err, ff_rx_dval, ff_rx_rdy;
    logic [1:0]  ff_rx_mod;
    logic [31:0] pay_data;
    logic        pay_valid, pay_ready, pay_sop, pay_eop;
    logic [1:0]  pay_empty;
    logic [15:0] cnt_ok, cnt_filt, cnt_err, cnt_ovf;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_out;
    int          m_ok, m_filt, m_err, m_ovf;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          out_cnt = 0;
    int          rdy_mode = 0;
    logic        hold_v = 1'b0;
    logic        rst_q  = 1'b0;
    logic [36:0] hold_s;

    mpu_rx_frame_filter #(.DEPTH_LOG2(DL2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ff_rx_data (ff_rx_data),
        .ff_rx_sop  (ff_rx_sop),
        .ff_rx_eop  (ff_rx_eop),
        .ff_rx_mod  (ff_rx_mod),
        .ff_rx_err  (ff_rx_err),
        .ff_rx_dval (ff_rx_dval),
        .ff_rx_rdy  (ff_rx_rdy),
        .pay_data   (pay_data),
        .pay_valid  (pay_valid),
        .pay_ready  (pay_ready),
        .pay_sop    (pay_sop),
        .pay_eop    (pay_eop),
        .pay_empty  (pay_empty),
        .cnt_ok     (cnt_ok),
        .cnt_filt   (cnt_filt),
        .cnt_err    (cnt_err),
        .cnt_ovf    (cnt_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output compare: every transfer against the model queue, plus stall stability
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_v = 1'b0;
            rst_q  = 1'b0;
        end else begin
            if (rst_q) check("rx_rdy", 64'(ff_rx_rdy), 64'd1);
            rst_q = 1'b1;
            if (hold_v) check("hold", 64'({pay_valid, pay_sop, pay_eop, pay_empty, pay_data}), 64'(hold_s));
            if (pay_valid && pay_ready) begin
                hold_v = 1'b0;
                check("word_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pay_word", {27'd0, pay_sop, pay_eop, pay_empty, pay_data},
                          {27'd0, e.sop, e.eop, e.empty, e.data});
                end
                last_out = '{pay_data, pay_sop, pay_eop, pay_empty};
                out_cnt++;
            end else if (pay_valid) begin
                hold_v = 1'b1;
                hold_s = {pay_valid, pay_sop, pay_eop, pay_empty, pay_data};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // MPU-side ready pattern
    initial begin
        pay_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       pay_ready = 1'b1;
                1:       pay_ready = 1'b0;
                2:       pay_ready = !pay_ready;
                default: pay_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [31:0] d, input logic s, input logic e,
                         input logic [1:0] m, input logic er, input logic v);
        ff_rx_data = d; ff_rx_sop = s; ff_rx_eop = e;
        ff_rx_mod = m; ff_rx_err = er; ff_rx_dval = v;
        @(posedge clk); #1;
        ff_rx_dval = 1'b0;
    endtask

    task automatic check_counters();
        check("cnt_ok",   64'(cnt_ok),   64'(m_ok));
        check("cnt_filt", 64'(cnt_filt), 64'(m_filt));
        check("cnt_err",  64'(cnt_err),  64'(m_err));
        check("cnt_ovf",  64'(cnt_ovf),  64'(m_ovf));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ff_rx_dval = 1'b0;
        exp_q.delete();
        m_ok = 0; m_filt = 0; m_err = 0; m_ovf = 0;
        repeat (3) begin @(posedge clk); #1; end
        check("rdy_in_reset", 64'(ff_rx_rdy), 64'd0);
        check("out_in_reset", 64'({pay_valid, pay_sop, pay_eop, pay_empty, pay_data}), 64'd0);
        check_counters();
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_reset", 64'(ff_rx_rdy), 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !pay_valid) break;
            @(posedge clk); #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    // Model classifies the whole frame from its header fields and length, then words are sent
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int n,
                              input logic [1:0] lmod, input logic err, input logic trunc,
                              input logic gaps, input logic [31:0] base);
        logic        hdr_ok, good, last;
        logic [31:0] w;
        hdr_ok = ((dst == MAC) || (dst == BCAST)) && (et == ET_OK);
        good   = 1'b0;
        if (trunc) begin
            if (n >= 4 && !hdr_ok) m_filt++; else m_err++;
        end else if (n <= 4 || !hdr_ok) m_filt++;
        else if (n - 4 > CAP) m_ovf++;
        else if (err) m_err++;
        else begin
            m_ok++;
            good = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                drive($urandom, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b0);
            case (k)
                0:       w = {16'($urandom), dst[47:32]};
                1:       w = dst[31:0];
                2:       w = $urandom;
                3:       w = {16'($urandom), et};
                default: w = (base == 32'd0) ? $urandom : base + 32'(k - 4);
            endcase
            last = (k == n - 1) && !trunc;
            if (good && k >= 4)
                exp_q.push_back('{w, (k == 4), last, last ? lmod : 2'd0});
            drive(w, (k == 0), last, last ? lmod : 2'($urandom), last ? err : 1'($urandom), 1'b1);
        end
    endtask

    initial begin
        int base_cnt;
        ff_rx_data = 32'd0; ff_rx_sop = 1'b0; ff_rx_eop = 1'b0;
        ff_rx_mod = 2'd0; ff_rx_err = 1'b0; ff_rx_dval = 1'b0;
        do_reset();

        // 1: good frame, 8 payload words, last mod 2
        rdy_mode = 0;
        send_frame(MAC, ET_OK, 12, 2'd2, 1'b0, 1'b0, 1'b0, 32'hC0DE_0000);
        wait_drain();
        check("t1_words", 64'(out_cnt), 64'd8);
        check("t1_last", {27'd0, last_out.sop, last_out.eop, last_out.empty, last_out.data},
              {27'd0, 1'b0, 1'b1, 2'd2, 32'hC0DE_0007});
        check("t1_cnt_ok", 64'(cnt_ok), 64'd1);
        check_counters();

        // 2: wrong EtherType dropped, broadcast accepted
        send_frame(MAC, ET_IP, 12, 2'd0, 1'b0, 1'b0, 1'b0, 32'h1111_0000);
        send_frame(BCAST, ET_OK, 12, 2'd1, 1'b0, 1'b0, 1'b0, 32'h2222_0000);
        wait_drain();
        check("t2_cnt_filt", 64'(cnt_filt), 64'd1);
        check("t2_cnt_ok", 64'(cnt_ok), 64'd2);
        check_counters();

        // 3: errored frame rolled back, following 3-word frame forwarded
        base_cnt = out_cnt;
        send_frame(MAC, ET_OK, 9, 2'd0, 1'b1, 1'b0, 1'b0, 32'h3333_0000);
        send_frame(MAC, ET_OK, 7, 2'd3, 1'b0, 1'b0, 1'b0, 32'h4444_0000);
        wait_drain();
        check("t3_words", 64'(out_cnt - base_cnt), 64'd3);
        check("t3_cnt_err", 64'(cnt_err), 64'd1);
        check_counters();

        // 4: overflow with output stalled, then recovery
        rdy_mode = 1;
        repeat (2) begin @(posedge clk); #1; end
        send_frame(MAC, ET_OK, 24, 2'd0, 1'b0, 1'b0, 1'b0, 32'h5555_0000);
        repeat (6) begin @(posedge clk); #1; end
        check("t4_no_valid", 64'(pay_valid), 64'd0);
        check("t4_cnt_ovf", 64'(cnt_ovf), 64'd1);
        base_cnt = out_cnt;
        send_frame(MAC, ET_OK, 8, 2'd0, 1'b0, 1'b0, 1'b0, 32'h6666_0000);
        rdy_mode = 0;
        wait_drain();
        check("t4_words", 64'(out_cnt - base_cnt), 64'd4);
        check_counters();

        // 5: back-to-back frames with toggling ready
        rdy_mode = 2;
        base_cnt = out_cnt;
        send_frame(MAC, ET_OK, 10, 2'd1, 1'b0, 1'b0, 1'b0, 32'h7777_0000);
        send_frame(BCAST, ET_OK, 10, 2'd2, 1'b0, 1'b0, 1'b0, 32'h8888_0000);
        wait_drain();
        check("t5_words", 64'(out_cnt - base_cnt), 64'd12);
        check("t5_cnt_ok", 64'(cnt_ok), 64'd6);
        check_counters();

        // 6: reset mid-payload, orphan words, then a good frame
        rdy_mode = 0;
        drive({16'h1234, MAC[47:32]}, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        drive(MAC[31:0], 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        drive(32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        drive({16'h0000, ET_OK}, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        drive(32'hAAAA_0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        drive(32'hAAAA_0002, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++)
            drive($urandom, 1'b0, (i == 2), 2'($urandom), 1'b0, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        check("t6_no_valid", 64'(pay_valid), 64'd0);
        check_counters();
        base_cnt = out_cnt;
        send_frame(MAC, ET_OK, 7, 2'd0, 1'b0, 1'b0, 1'b0, 32'h9999_0000);
        wait_drain();
        check("t6_words", 64'(out_cnt - base_cnt), 64'd3);
        check("t6_cnt_ok", 64'(cnt_ok), 64'd1);
        check_counters();

        // Randomized frames: mixed addresses, EtherTypes, runts, errors, aborts and gaps
        rdy_mode = 3;
        for (int f = 0; f < 40; f++) begin
            logic [47:0] dst;
            logic [15:0] et;
            int          kind, n, sel;
            sel = $urandom_range(0, 4);
            dst = (sel <= 1) ? MAC : (sel == 2) ? BCAST : (sel == 3) ? OTHER : {16'($urandom), 32'($urandom)};
            et  = ($urandom_range(0, 3) == 0) ? ET_IP : ET_OK;
            kind = $urandom_range(0, 9);
            n = (kind == 0) ? $urandom_range(2, 4) : (kind == 1) ? $urandom_range(1, 8) : $urandom_range(5, 16);
            send_frame(dst, et, n, 2'($urandom), ($urandom_range(0, 4) == 0), (kind == 1), 1'b1, 32'd0);
            if (kind != 1 && $urandom_range(0, 2) == 0)
                drive($urandom, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 1'b1);
            wait_drain();
            if (kind != 1) check_counters();
        end
        send_frame(MAC, ET_OK, 9, 2'd1, 1'b0, 1'b0, 1'b1, 32'd0);
        wait_drain();
        check_counters();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mpu_rx_frame_filter.md
Name: mpu_rx_frame_filter

Overview:
Store-and-forward receive filter between the TSE MAC receive FIFO interface (Avalon-ST, 32-bit, RX shift16 enabled) and the MPU subsystem's receive data input.
- Checks destination MAC, EtherType and frame error status for each frame.
- Strips the 14-byte Ethernet header plus the 2 pad bytes.
- Forwards only the payload of good frames as an Avalon-ST packet.
- Discards bad frames by rolling back the write pointer; keeps saturating statistics counters.

Parameters:
DEPTH_LOG2, 9, log2 of payload buffer depth in 32-bit words (512 words; holds a 1500-byte payload)
MAC_ADDR, 48'h02_00_00_00_00_01, unicast address accepted
ETHERTYPE, 16'h88B5, only EtherType forwarded
ACCEPT_BCAST, 1, also accept destination FF:FF:FF:FF:FF:FF
CNT_W, 16, statistics counter width

Ports:
clk  in  1  system clock; MAC FIFO side and MPU side share this clock
reset_n  in  1  asynchronous active-low reset
ff_rx_data  in  32  MAC receive data; byte 0 in [31:24]
ff_rx_sop  in  1  start of packet
ff_rx_eop  in  1  end of packet
ff_rx_mod  in  2  invalid bytes in the eop word
ff_rx_err  in  1  frame error; qualified with eop
ff_rx_dval  in  1  data valid
ff_rx_rdy  out  1  ready to MAC
pay_data  out  32  payload word to MPU
pay_valid  out  1  payload valid
pay_ready  in  1  MPU ready
pay_sop  out  1  first payload word
pay_eop  out  1  last payload word
pay_empty  out  2  invalid bytes in the pay_eop word
cnt_ok  out  CNT_W  frames forwarded
cnt_filt  out  CNT_W  frames dropped for address, EtherType or runt
cnt_err  out  CNT_W  frames dropped for ff_rx_err or missing eop
cnt_ovf  out  CNT_W  frames dropped because the buffer was full

Behaviour:
Reset values:
- All outputs 0, except ff_rx_rdy, which is 0 during reset and 1 from the first clk after reset_n deasserts.
- Pointers wr, commit and rd are 0. State is IDLE.

Input rules:
- ff_rx_rdy stays 1 at all times. The block never backpressures the MAC; overflow is handled by dropping.
- A word is accepted when ff_rx_dval && ff_rx_rdy.

Frame word layout (shift16):
- w0[15:0] = dst[0:1]
- w1 = dst[2:5]
- w2 = src[0:3]
- w3[15:0] = EtherType
- w4 onward = payload

State machine (IDLE, HDR, PAY, DROP):
- IDLE: non-sop words are ignored. A sop word goes to HDR, resets the header word index hidx to 0 and captures dst[0:1].
- HDR: hidx increments per accepted word.
  - At hidx=3 the header is evaluated:
    - Destination match = (dst == MAC_ADDR) || (ACCEPT_BCAST && dst == all-ones).
    - EtherType match = (w3[15:0] == ETHERTYPE).
    - Both match -> PAY. Otherwise -> DROP and cnt_filt+1.
  - eop in HDR (runt) -> cnt_filt+1, go to IDLE.
- PAY: each word is written to the buffer as {data, eop, mod} (35 bits); wr increments.
  - eop with ff_rx_err=0: commit <= wr+1, cnt_ok+1, go to IDLE.
  - eop with ff_rx_err=1: wr <= commit, cnt_err+1, go to IDLE.
  - Buffer full at the write attempt ((wr+1)==rd): word is not written, wr <= commit, cnt_ovf+1. The same word with eop goes to IDLE; otherwise go to DROP.
  - sop while in PAY: wr <= commit, cnt_err+1, the new frame starts in HDR.
- DROP: words are discarded until eop, then IDLE. A sop in DROP starts HDR.
- sop while in HDR: restart HDR with the new word; cnt_err+1.

Output side:
- The buffer is a simple dual-port RAM with 1-cycle read latency, followed by a single output register stage.
- Only words in [rd, commit) are readable.
- pay_valid asserts 2 cycles after the commit cycle when the output stage is empty.
- pay_valid and all pay_* outputs hold stable while pay_ready=0.
- pay_sop is 1 on the first word after reset or after a word with pay_eop.
- With pay_ready held at 1, throughput is 1 word per cycle, back to back across frames.
- pay_empty equals the stored mod, and is 0 when pay_eop=0.

Counters saturate at all-ones.

Pointers are DEPTH_LOG2 bits and wrap naturally. Full is (wr+1)==rd; empty is rd==commit.

Decomposition:
- Package mpu_eth_pkg holds:
  - state enum rx_filt_state_t
  - buffer entry struct {data[31:0], eop, mod[1:0]}
  - constants BCAST_ADDR, HDR_WORDS=4
- One sub-module, mpu_sdp_ram (parameterised width/depth, registered read), holds the payload buffer.

Test Plan:
1. Good frame to MAC_ADDR, EtherType 88B5, 8 payload words, last ff_rx_mod=2, pay_ready=1 -> 8 pay words, sop on word 1, eop on word 8, pay_empty=2; cnt_ok=1.
2. Same frame but EtherType 0800, then a broadcast 88B5 frame -> first dropped with cnt_filt=1; second forwarded with cnt_ok=1.
3. Good header, eop with ff_rx_err=1 after 5 payload words, then a good 3-word frame -> only 3 words out; cnt_err=1.
4. DEPTH_LOG2=4, pay_ready=0, 20-word payload frame -> dropped, cnt_ovf=1, no pay_valid. Next 4-word frame is forwarded after pay_ready=1.
5. Two good frames back to back, pay_ready toggling 1,0 -> 12 total words in order, pay_* held stable while pay_ready=0, correct sop/eop per frame.
6. reset_n pulsed low mid-PAY, then dval words without sop, then a good frame -> orphan words ignored, only the good frame output, all counters restart at 0.
